// File: rtl/gen_clock_frac.sv
// gen_clock_frac: multi-channel fractional clock generator using per-channel phase accumulators
//   clock_in  system clock, all logic on rising edge
//   reset_n   asynchronous active-low reset
//   enable    1 = generators step, 0 = freeze (acc, clock_out, cfg_err held, tick low)
//   load      1-cycle strobe: latch in_freq/out_freq (and phase), realign all channels
//   in_freq   clock_in frequency in Hz
//   out_freq  channel i target frequency at [i*FREQ_W +: FREQ_W]
//   phase     (only with GEN_CLOCK_PHASE_EN) channel i initial accumulator value
//   clock_out generated clocks, registered
//   tick      1-cycle pulse on each 0->1 of clock_out[i]
//   cfg_err   channel i holds an illegal config (2*out > in)
// Optional feature macro: GEN_CLOCK_PHASE_EN
module gen_clock_frac #(
    parameter int NUM_CH = 3,
    parameter int FREQ_W = 32
) (
    input  logic                     clock_in,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic                     load,
    input  logic [FREQ_W-1:0]        in_freq,
    input  logic [NUM_CH*FREQ_W-1:0] out_freq,
`ifdef GEN_CLOCK_PHASE_EN
    input  logic [NUM_CH*FREQ_W-1:0] phase,
`endif
    output logic [NUM_CH-1:0]        clock_out,
    output logic [NUM_CH-1:0]        tick,
    output logic [NUM_CH-1:0]        cfg_err
);

    logic [FREQ_W-1:0] in_f_r;

    always_ff @(posedge clock_in or negedge reset_n)
        if (!reset_n)
            in_f_r <= '0;
        else if (load)
            in_f_r <= in_freq;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [FREQ_W-1:0] out_r, acc, acc_nxt, init;
        logic [FREQ_W:0]   sum;
        logic              wrap, run, co, tk, er;
`ifdef GEN_CLOCK_PHASE_EN
        assign init = (phase[i*FREQ_W +: FREQ_W] < in_freq) ? phase[i*FREQ_W +: FREQ_W] : '0;
`else
        assign init = '0;
`endif
        // One extra bit keeps acc + 2*out exact; acc < in and 2*out <= in bound the result.
        always_comb begin
            sum     = {1'b0, acc} + {out_r, 1'b0};
            wrap    = sum >= {1'b0, in_f_r};
            acc_nxt = wrap ? FREQ_W'(sum - {1'b0, in_f_r}) : FREQ_W'(sum);
            run     = enable && (out_r != '0) && !er;
        end
        always_ff @(posedge clock_in or negedge reset_n)
            if (!reset_n) begin
                out_r <= '0;
                acc   <= '0;
                co    <= 1'b0;
                tk    <= 1'b0;
                er    <= 1'b0;
            end else if (load) begin
                out_r <= out_freq[i*FREQ_W +: FREQ_W];
                acc   <= init;
                co    <= 1'b0;
                tk    <= 1'b0;
                er    <= {out_freq[i*FREQ_W +: FREQ_W], 1'b0} > {1'b0, in_freq};
            end else if (run) begin
                acc   <= acc_nxt;
                co    <= co ^ wrap;
                tk    <= wrap && !co;
            end else
                tk    <= 1'b0;
        assign clock_out[i] = co;
        assign tick[i]      = tk;
        assign cfg_err[i]   = er;
    end

endmodule

// File: tb/tb_gen_clock_frac.sv
// tb_gen_clock_frac: directed scoreboard bench for gen_clock_frac
module tb_gen_clock_frac;
    localparam int N = 3;
    localparam int W = 32;

    logic           clock_in = 1'b0;
    logic           reset_n  = 1'b1;
    logic           enable   = 1'b0;
    logic           load     = 1'b0;
    logic [W-1:0]   in_freq  = '0;
    logic [N*W-1:0] out_freq = '0;
`ifdef GEN_CLOCK_PHASE_EN
    logic [N*W-1:0] phase    = '0;
`endif
    logic [N-1:0]   clock_out, tick, cfg_err;

    int checks   = 0;
    int failures = 0;

    // Closed-form reference: after n enabled steps channel i has toggled
    // floor((ph + 2*out*n) / in) times.
    longint unsigned m_in;
    longint unsigned m_out[N];
    longint unsigned m_ph[N];
    longint unsigned n_en;
    bit              stepped;
    int              tick_cnt[N];

    typedef struct {
        string          tag;
        logic [3*N-1:0] exp;
    } item_t;
    item_t sb[$];

    always #5 clock_in = ~clock_in;

    gen_clock_frac #(.NUM_CH(N), .FREQ_W(W)) dut (
        .clock_in (clock_in),
        .reset_n  (reset_n),
        .enable   (enable),
        .load     (load),
        .in_freq  (in_freq),
        .out_freq (out_freq),
`ifdef GEN_CLOCK_PHASE_EN
        .phase    (phase),
`endif
        .clock_out(clock_out),
        .tick     (tick),
        .cfg_err  (cfg_err)
    );

    function automatic longint unsigned toggles(int i, longint unsigned n);
        return (m_ph[i] + 2 * m_out[i] * n) / m_in;
    endfunction

    function automatic logic [3*N-1:0] expect_vec();
        logic [N-1:0] co, tk, er;
        longint unsigned c, p;
        co = '0;
        tk = '0;
        er = '0;
        for (int i = 0; i < N; i++) begin
            er[i] = (2 * m_out[i]) > m_in;
            if (m_out[i] != 0 && !er[i]) begin
                c     = toggles(i, n_en);
                co[i] = c[0];
                if (stepped) begin
                    p     = toggles(i, n_en - 1);
                    tk[i] = co[i] && (c != p);
                end
            end
        end
        return {er, tk, co};
    endfunction

    task automatic check_pop();
        item_t it;
        it = sb.pop_front();
        checks++;
        assert ({cfg_err, tick, clock_out} === it.exp)
        else begin
            failures++;
            $error("FAIL %s got={err,tick,clk}=%b exp=%b", it.tag, {cfg_err, tick, clock_out}, it.exp);
        end
    endtask

    task automatic check_now(string tag);
        sb.push_back('{tag, expect_vec()});
        check_pop();
    endtask

    task automatic cycle(string tag, bit en, bit ld);
        enable = en;
        load   = ld;
        if (ld) begin
            n_en    = 0;
            stepped = 0;
        end else if (en) begin
            n_en++;
            stepped = 1;
        end else
            stepped = 0;
        sb.push_back('{tag, expect_vec()});
        @(posedge clock_in);
        #1;
        check_pop();
        for (int i = 0; i < N; i++)
            if (tick[i] === 1'b1) tick_cnt[i]++;
    endtask

    task automatic run(string tag, bit en, int n);
        for (int k = 0; k < n; k++) cycle(tag, en, 0);
    endtask

    task automatic do_load(string tag, bit en, longint unsigned fin,
                           longint unsigned o0, longint unsigned o1, longint unsigned o2,
                           longint unsigned p0, longint unsigned p1, longint unsigned p2);
        longint unsigned ph[N];
        ph[0] = p0;
        ph[1] = p1;
        ph[2] = p2;
        in_freq  = W'(fin);
        out_freq = {W'(o2), W'(o1), W'(o0)};
`ifdef GEN_CLOCK_PHASE_EN
        phase    = {W'(p2), W'(p1), W'(p0)};
`endif
        m_in     = fin;
        m_out[0] = o0;
        m_out[1] = o1;
        m_out[2] = o2;
        for (int i = 0; i < N; i++) begin
`ifdef GEN_CLOCK_PHASE_EN
            m_ph[i] = (ph[i] < fin) ? ph[i] : 0;
`else
            m_ph[i] = (ph[i] == ph[i]) ? 0 : 0;
`endif
        end
        cycle(tag, en, 1);
        load = 1'b0;
    endtask

    initial begin
        m_in = 0;
        n_en = 0;
        stepped = 0;
        for (int i = 0; i < N; i++) begin
            m_out[i] = 0;
            m_ph[i]  = 0;
            tick_cnt[i] = 0;
        end
        #1 reset_n = 1'b0;
        #10 check_now("reset_state");
        #2 reset_n = 1'b1;
        run("idle_before_load", 1, 3);

        do_load("t1_load", 0, 8, 1, 2, 4, 0, 0, 0);
        run("t1_run", 1, 16);

        in_freq  = W'(5);
        out_freq = {W'(1), W'(1), W'(2)};
        run("ports_ignored", 1, 4);

        run("t4_freeze", 0, 5);
        run("t4_resume", 1, 6);
        do_load("t4_load_with_en", 1, 8, 1, 2, 4, 0, 0, 0);
        run("t4_after_realign", 1, 5);

        do_load("t2_load", 1, 10, 3, 0, 0, 0, 0, 0);
        tick_cnt[0] = 0;
        run("t2_run", 1, 10);
        checks++;
        assert (tick_cnt[0] == 3)
        else begin
            failures++;
            $error("FAIL t2_rises_per_10 got=%0d exp=3", tick_cnt[0]);
        end
        run("t2_more", 1, 10);

        do_load("t3_load", 1, 10, 3, 6, 5, 0, 0, 0);
        run("t3_run", 1, 8);
        do_load("t3_in_zero", 0, 0, 1, 0, 0, 0, 0, 0);
        run("t3_in_zero_run", 1, 3);

        do_load("t5_load", 0, 8, 1, 2, 4, 0, 0, 0);
        run("t5_run", 1, 3);
        #2 reset_n = 1'b0;
        m_in = 0;
        n_en = 0;
        stepped = 0;
        for (int i = 0; i < N; i++) begin
            m_out[i] = 0;
            m_ph[i]  = 0;
        end
        #1 check_now("t5_async_reset");
        #2 reset_n = 1'b1;
        run("t5_idle_after_reset", 1, 4);

`ifdef GEN_CLOCK_PHASE_EN
        do_load("t6_phase6", 0, 8, 1, 2, 0, 6, 3, 0);
        run("t6_phase6_run", 1, 10);
        do_load("t6_phase9", 0, 8, 1, 0, 0, 9, 0, 0);
        run("t6_phase9_run", 1, 10);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
